// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin memory bus controller with region decode and programmable wait states.
// Optional BUS_ERR_EN macro: when defined, an unmapped access pulses bus_err in its ack cycle.
module mem_bus_arbiter #(
   parameter int AW       = 14,
   parameter int DW       = 32,
   parameter int WAIT_CYC = 1
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_re,
   output logic          mem_we,
   output logic          nce_rom,
   output logic          nce_ram,
   output logic          nce_out,
   output logic          bus_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

   state_t        state_reg, state_next;
   logic [3:0]    cnt_reg, cnt_next;
   logic          last_grant_reg, last_grant_next;
   logic          gnt_reg, gnt_next;
   logic          we_reg, we_next;
   logic [AW-1:0] mem_addr_reg, mem_addr_next;
   logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
   logic [DW-1:0] rdata_reg, rdata_next;

   logic [1:0]    req_vec;
   logic [1:0]    we_vec;
   logic [1:0]    ack_vec;
   logic [AW-1:0] addr_arr  [2];
   logic [DW-1:0] wdata_arr [2];
   logic          pick;
   logic [2:0]    region;
   logic          mapped;
   logic          in_access;

   assign req_vec      = {req1, req0};
   assign we_vec       = {we1, we0};
   assign addr_arr[0]  = addr0;
   assign addr_arr[1]  = addr1;
   assign wdata_arr[0] = wdata0;
   assign wdata_arr[1] = wdata1;

   // On a tie the port that did not win last time is served; otherwise the lone requester.
   assign pick = (&req_vec) ? ~last_grant_reg : req_vec[1];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         last_grant_reg <= 1'b1;
         gnt_reg        <= 1'b0;
         we_reg         <= 1'b0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
         rdata_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         last_grant_reg <= last_grant_next;
         gnt_reg        <= gnt_next;
         we_reg         <= we_next;
         mem_addr_reg   <= mem_addr_next;
         mem_wdata_reg  <= mem_wdata_next;
         rdata_reg      <= rdata_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      last_grant_next = last_grant_reg;
      gnt_next        = gnt_reg;
      we_next         = we_reg;
      mem_addr_next   = mem_addr_reg;
      mem_wdata_next  = mem_wdata_reg;
      rdata_next      = rdata_reg;
      case (state_reg)
         IDLE: begin
            if (|req_vec) begin
               gnt_next        = pick;
               last_grant_next = pick;
               we_next         = we_vec[pick];
               mem_addr_next   = addr_arr[pick];
               mem_wdata_next  = wdata_arr[pick];
               cnt_next        = WAIT_INIT;
               state_next      = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end else begin
               // Unmapped reads return zero rather than whatever floats on the bus.
               if (!we_reg) begin
                  rdata_next = mapped ? mem_rdata : '0;
               end
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign region    = mem_addr_reg[AW-1 -: 3];
   assign mapped    = (region < 3'd3);
   assign in_access = (state_reg == ACCESS);

   assign nce_rom = !(in_access && (region == 3'd0));
   assign nce_ram = !(in_access && (region == 3'd1));
   assign nce_out = !(in_access && (region == 3'd2));

   // ROM is read-only: its enable still asserts on a write, but no write strobe is issued.
   assign mem_re = in_access && !we_reg && mapped;
   assign mem_we = in_access && we_reg && ((region == 3'd1) || (region == 3'd2));

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ack
         assign ack_vec[gi] = (state_reg == DONE) && (int'(gnt_reg) == gi);
      end
   endgenerate

   assign ack0      = ack_vec[0];
   assign ack1      = ack_vec[1];
   assign rdata     = rdata_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;

`ifdef BUS_ERR_EN
   assign bus_err = (state_reg == DONE) && !mapped;
`else
   assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized self-checking bench for mem_bus_arbiter against a transaction-level model.
// Honors BUS_ERR_EN the same way as the design.
module tb_mem_bus_arbiter;

   localparam int W = 1;
`ifdef BUS_ERR_EN
   localparam bit BERR = 1'b1;
`else
   localparam bit BERR = 1'b0;
`endif

   logic        clk;
   logic        nrst;
   logic        req0, req1, we0, we1;
   logic [13:0] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        ack0, ack1;
   logic [31:0] rdata;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_re, mem_we;
   logic        nce_rom, nce_ram, nce_out;
   logic        bus_err;

   logic [31:0] rd_base;
   logic [4:0]  bus;
   int          total;
   int          bad;
   logic        last_grant_m;
   logic [31:0] rdata_m;

   mem_bus_arbiter #(.AW(14), .DW(32), .WAIT_CYC(W)) dut (
      .clk(clk), .nrst(nrst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_re(mem_re), .mem_we(mem_we),
      .nce_rom(nce_rom), .nce_ram(nce_ram), .nce_out(nce_out),
      .bus_err(bus_err)
   );

   // Memory contents are a simple function of the address so every read has a known answer.
   assign mem_rdata = rd_base ^ {18'h0, mem_addr};
   assign bus       = {nce_rom, nce_ram, nce_out, mem_re, mem_we};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] exp_bus(input logic w, input logic [2:0] r);
      exp_bus = {(r != 3'd0), (r != 3'd1), (r != 3'd2),
                 (!w && (r < 3'd3)), (w && ((r == 3'd1) || (r == 3'd2)))};
   endfunction

   task automatic drop_req(input logic g);
      if (g) req1 = 1'b0;
      else   req0 = 1'b0;
   endtask

   // Runs one request pattern (port 0, port 1 or both) to completion, checking every cycle.
   task automatic run_txn(input logic [1:0] ports, input logic [1:0] wv,
                          input logic [13:0] a0, input logic [13:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input bit drop_early);
      logic [1:0]  pend;
      logic        g;
      logic        ew;
      logic [13:0] ea;
      logic [31:0] ed;
      logic [2:0]  rg;
      bit          first;
      pend  = ports;
      first = 1'b1;
      @(negedge clk);
      req0 = ports[0]; we0 = wv[0]; addr0 = a0; wdata0 = d0;
      req1 = ports[1]; we1 = wv[1]; addr1 = a1; wdata1 = d1;
      while (pend != 2'b00) begin
         g  = (pend == 2'b11) ? ~last_grant_m : pend[1];
         last_grant_m = g;
         ew = wv[g];
         ea = g ? a1 : a0;
         ed = g ? d1 : d0;
         rg = ea[13:11];
         if (!first) begin
            @(negedge clk);
            chk("idle_gap", {bus, ack1, ack0}, {5'b11100, 2'b00});
         end
         first = 1'b0;
         for (int c = 1; c <= W + 1; c++) begin
            @(negedge clk);
            chk("bus", bus, exp_bus(ew, rg));
            chk("mem_addr", mem_addr, ea);
            chk("mem_wdata", mem_wdata, ed);
            chk("no_ack", {ack1, ack0}, 2'b00);
            chk("no_berr", bus_err, 1'b0);
            if (drop_early && c == 1) drop_req(g);
         end
         @(negedge clk);
         chk("ack", {ack1, ack0}, g ? 2'b10 : 2'b01);
         if (!ew) rdata_m = (rg < 3'd3) ? (rd_base ^ {18'h0, ea}) : 32'h0;
         chk("rdata", rdata, rdata_m);
         chk("bus_done", bus, 5'b11100);
         chk("bus_err", bus_err, BERR && (rg >= 3'd3));
         drop_req(g);
         pend[g] = 1'b0;
         $display("txn port=%0d we=%0b addr=%04h wdata=%08h rdata=%08h", g, ew, ea, ed, rdata);
      end
   endtask

   // Both ports held high through three acks: strict alternation with one idle cycle between.
   task automatic rr_held();
      logic        g;
      int          idx;
      int          last_idx;
      int          acks;
      logic [13:0] ea;
      rd_base = $urandom;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0820; wdata0 = 32'h0;
      req1 = 1'b1; we1 = 1'b0; addr1 = 14'h0C40; wdata1 = 32'h0;
      g = ~last_grant_m;
      idx = 0; last_idx = 0; acks = 0;
      while (acks < 3 && idx < 60) begin
         @(negedge clk);
         idx++;
         if (ack0 || ack1) begin
            chk("rr_port", {ack1, ack0}, g ? 2'b10 : 2'b01);
            chk("rr_gap", idx - last_idx, (acks == 0) ? W + 2 : W + 3);
            ea = g ? addr1 : addr0;
            rdata_m = rd_base ^ {18'h0, ea};
            chk("rr_rdata", rdata, rdata_m);
            $display("txn rr port=%0d addr=%04h rdata=%08h", g, ea, rdata);
            last_grant_m = g;
            g = ~g;
            last_idx = idx;
            acks++;
         end
      end
      if (acks < 3) chk("rr_timeout", acks, 3);
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      total = 0; bad = 0;
      last_grant_m = 1'b1;
      rdata_m = 32'h0;
      rd_base = 32'h0;
      nrst = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      repeat (3) @(negedge clk);
      chk("rst_bus", {bus, ack1, ack0, bus_err}, {5'b11100, 3'b000});
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_mem_addr", mem_addr, 14'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      nrst = 1'b1;

      // Read from RAM returning a known word.
      rd_base = 32'h1234_5678 ^ 32'h0000_0804;
      run_txn(2'b01, 2'b00, 14'h0804, 14'h0000, 32'h0, 32'h0, 1'b0);
      chk("t1_rdata", rdata, 32'h1234_5678);

      rr_held();

      // Write to the output region from port 1 leaves rdata alone.
      run_txn(2'b10, 2'b10, 14'h0000, 14'h1000, 32'h0, 32'h0000_03FF, 1'b0);
      // ROM write: enable only, no strobe.
      run_txn(2'b01, 2'b01, 14'h0000, 14'h0000, 32'hDEAD_BEEF, 32'h0, 1'b0);
      // Unmapped read.
      rd_base = 32'hCAFE_F00D;
      run_txn(2'b01, 2'b00, 14'h3800, 14'h0000, 32'h0, 32'h0, 1'b0);
      // Request dropped mid-access still completes.
      run_txn(2'b01, 2'b00, 14'h0910, 14'h0000, 32'h0, 32'h0, 1'b1);

      // Reset in the middle of an access.
      rd_base = $urandom;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0810;
      @(negedge clk);
      chk("pre_rst_re", mem_re, 1'b1);
      #2 nrst = 1'b0;
      #1;
      chk("mid_rst_bus", {bus, ack1, ack0, bus_err}, {5'b11100, 3'b000});
      chk("mid_rst_addr", mem_addr, 14'h0);
      chk("mid_rst_rdata", rdata, 32'h0);
      req0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_no_ack", {ack1, ack0}, 2'b00);
      end
      nrst = 1'b1;
      last_grant_m = 1'b1;
      rdata_m = 32'h0;
      run_txn(2'b01, 2'b00, 14'h0804, 14'h0000, 32'h0, 32'h0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         rd_base = $urandom;
         run_txn(2'($urandom_range(1, 3)), 2'($urandom), 14'($urandom), 14'($urandom),
                 $urandom, $urandom, ($urandom_range(0, 3) == 0));
      end

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
